// File: rtl/lpm_pkg.sv
// lpm_pkg: shared definitions for the longest-prefix-match route table.
//   NUM_ENTRIES / IDX_WIDTH : table depth and matching index width
//   lpm_entry_t             : one route entry {valid, ip, mask, nh, oq}
//   lpm_state_t             : lookup sequencer states
package lpm_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int IDX_WIDTH   = 5;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [31:0] mask;
    logic [31:0] nh;
    logic [31:0] oq;
  } lpm_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lpm_state_t;

endpackage

// File: rtl/lpm_entry_match.sv
// lpm_entry_match: combinational compare of one route entry against a key.
//   entry     in  route entry under test
//   key       in  destination address being looked up
//   best_mask in  mask of the best entry found so far
//   best_hit  in  an earlier entry already matched
//   match     out entry is valid and its prefix covers the key
//   better    out entry's prefix would beat the current best (ignores match)
module lpm_entry_match
  import lpm_pkg::*;
(
  input  lpm_entry_t  entry,
  input  logic [31:0] key,
  input  logic [31:0] best_mask,
  input  logic        best_hit,
  output logic        match,
  output logic        better
);

  // nh/oq travel with the entry but play no part in the comparison.
  logic unused_payload;
  assign unused_payload = ^{entry.nh, entry.oq};

  assign match = entry.valid && ((key & entry.mask) == (entry.ip & entry.mask));

  // Masks are contiguous, so a larger unsigned mask is a longer prefix.
  // Strict compare keeps the earlier (lower) index on equal prefixes.
  assign better = !best_hit || (entry.mask > best_mask);

endmodule

// File: rtl/lpm_table_ctrl.sv
// lpm_table_ctrl: owns the route table and serialises host writes with a
// one-entry-per-cycle longest-prefix-match scan.
//   AXI_ACLK, AXI_RESETN           clock, async active-low reset
//   req_valid/req_ready/req_ip     lookup request (accepted only in IDLE)
//   rsp_valid/rsp_ready            lookup result handshake (held in DONE)
//   rsp_hit/rsp_index/rsp_nh/rsp_oq registered result, zeroed on miss
//   wr_valid/wr_ready/wr_index     host table write (stalled during SCAN)
//   wr_entry_valid, wr_ip, wr_mask, wr_nh, wr_oq   entry contents
//   entry_valid_vec                valid bit of every entry
//   lookup_count, miss_count       completed lookups / completed misses
module lpm_table_ctrl
  import lpm_pkg::*;
(
  input  logic                   AXI_ACLK,
  input  logic                   AXI_RESETN,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_ip,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic [IDX_WIDTH-1:0]   rsp_index,
  output logic [31:0]            rsp_nh,
  output logic [31:0]            rsp_oq,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [IDX_WIDTH-1:0]   wr_index,
  input  logic                   wr_entry_valid,
  input  logic [31:0]            wr_ip,
  input  logic [31:0]            wr_mask,
  input  logic [31:0]            wr_nh,
  input  logic [31:0]            wr_oq,
  output logic [NUM_ENTRIES-1:0] entry_valid_vec,
  output logic [31:0]            lookup_count,
  output logic [31:0]            miss_count
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

  lpm_state_t           state;
  logic [IDX_WIDTH-1:0] cnt;
  logic [31:0]          key;

  // Table: valid bits are reset, payload fields are plain storage.
  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [31:0]            ip_mem   [NUM_ENTRIES];
  logic [31:0]            mask_mem [NUM_ENTRIES];
  logic [31:0]            nh_mem   [NUM_ENTRIES];
  logic [31:0]            oq_mem   [NUM_ENTRIES];

  // Running best match across the scan.
  logic                 best_hit;
  logic [31:0]          best_mask;
  logic [IDX_WIDTH-1:0] best_idx;
  logic [31:0]          best_nh;
  logic [31:0]          best_oq;

  lpm_entry_t           cur_entry;
  logic                 cur_match;
  logic                 cur_better;
  logic                 take;
  logic                 nx_hit;
  logic [IDX_WIDTH-1:0] nx_idx;
  logic [31:0]          nx_nh;
  logic [31:0]          nx_oq;
  logic                 wr_fire;
  logic                 req_fire;

  assign req_ready       = (state == IDLE);
  assign wr_ready        = (state != SCAN);
  assign rsp_valid       = (state == DONE);
  assign entry_valid_vec = valid_vec;
  assign wr_fire         = wr_valid && wr_ready;
  assign req_fire        = req_valid && req_ready;

  always_comb begin
    cur_entry       = '0;
    cur_entry.valid = valid_vec[cnt];
    cur_entry.ip    = ip_mem[cnt];
    cur_entry.mask  = mask_mem[cnt];
    cur_entry.nh    = nh_mem[cnt];
    cur_entry.oq    = oq_mem[cnt];
  end

  lpm_entry_match u_match (
    .entry     (cur_entry),
    .key       (key),
    .best_mask (best_mask),
    .best_hit  (best_hit),
    .match     (cur_match),
    .better    (cur_better)
  );

  // Best-so-far including the entry being compared this cycle, so the final
  // scan cycle can load the response directly.
  assign take   = (state == SCAN) && cur_match && cur_better;
  assign nx_hit = best_hit || take;
  assign nx_idx = take ? cnt          : best_idx;
  assign nx_nh  = take ? cur_entry.nh : best_nh;
  assign nx_oq  = take ? cur_entry.oq : best_oq;

  // Control state, valid bits, response and statistics.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state        <= IDLE;
      cnt          <= '0;
      best_hit     <= 1'b0;
      valid_vec    <= '0;
      rsp_hit      <= 1'b0;
      rsp_index    <= '0;
      rsp_nh       <= '0;
      rsp_oq       <= '0;
      lookup_count <= '0;
      miss_count   <= '0;
    end else begin
      if (wr_fire) begin
        valid_vec[wr_index] <= wr_entry_valid;
      end
      case (state)
        IDLE: begin
          if (req_fire) begin
            state    <= SCAN;
            cnt      <= '0;
            best_hit <= 1'b0;
          end
        end
        SCAN: begin
          best_hit <= nx_hit;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state     <= DONE;
            rsp_hit   <= nx_hit;
            rsp_index <= nx_hit ? nx_idx : '0;
            rsp_nh    <= nx_hit ? nx_nh  : '0;
            rsp_oq    <= nx_hit ? nx_oq  : '0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state        <= IDLE;
            lookup_count <= lookup_count + 32'd1;
            if (!rsp_hit) begin
              miss_count <= miss_count + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath storage: key, best-match payload and table fields.
  always_ff @(posedge AXI_ACLK) begin
    if (req_fire) begin
      key <= req_ip;
    end
    if (take) begin
      best_mask <= cur_entry.mask;
      best_idx  <= cnt;
      best_nh   <= cur_entry.nh;
      best_oq   <= cur_entry.oq;
    end
    if (wr_fire) begin
      ip_mem[wr_index]   <= wr_ip;
      mask_mem[wr_index] <= wr_mask;
      nh_mem[wr_index]   <= wr_nh;
      oq_mem[wr_index]   <= wr_oq;
    end
  end

endmodule

// File: tb/tb_lpm_table_ctrl.sv
module tb_lpm_table_ctrl;

  logic        AXI_ACLK;
  logic        AXI_RESETN;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_ip;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [4:0]  rsp_index;
  logic [31:0] rsp_nh;
  logic [31:0] rsp_oq;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_index;
  logic        wr_entry_valid;
  logic [31:0] wr_ip, wr_mask, wr_nh, wr_oq;
  logic [31:0] entry_valid_vec;
  logic [31:0] lookup_count;
  logic [31:0] miss_count;

  lpm_table_ctrl dut (
    .AXI_ACLK        (AXI_ACLK),
    .AXI_RESETN      (AXI_RESETN),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_ip          (req_ip),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_hit         (rsp_hit),
    .rsp_index       (rsp_index),
    .rsp_nh          (rsp_nh),
    .rsp_oq          (rsp_oq),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_index        (wr_index),
    .wr_entry_valid  (wr_entry_valid),
    .wr_ip           (wr_ip),
    .wr_mask         (wr_mask),
    .wr_nh           (wr_nh),
    .wr_oq           (wr_oq),
    .entry_valid_vec (entry_valid_vec),
    .lookup_count    (lookup_count),
    .miss_count      (miss_count)
  );

  initial AXI_ACLK = 1'b0;
  always #5 AXI_ACLK = ~AXI_ACLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: table contents and statistics.
  bit          m_valid [32];
  logic [31:0] m_ip    [32];
  logic [31:0] m_mask  [32];
  logic [31:0] m_nh    [32];
  logic [31:0] m_oq    [32];
  int unsigned m_lookups = 0;
  int unsigned m_misses  = 0;

  // Expected result of the lookup in flight.
  logic        e_hit;
  logic [4:0]  e_idx;
  logic [31:0] e_nh, e_oq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pmask(input int len);
    return (len == 0) ? 32'h0 : (32'hFFFF_FFFF << (32 - len));
  endfunction

  // Longest prefix = most one-bits in the mask; ties go to the first index seen.
  task automatic model_lookup(input logic [31:0] ip);
    int best_len = -1;
    e_hit = 1'b0; e_idx = '0; e_nh = '0; e_oq = '0;
    for (int i = 0; i < 32; i++) begin
      if (m_valid[i] && ((ip & m_mask[i]) == (m_ip[i] & m_mask[i]))) begin
        if ($countones(m_mask[i]) > best_len) begin
          best_len = $countones(m_mask[i]);
          e_hit = 1'b1; e_idx = 5'(i); e_nh = m_nh[i]; e_oq = m_oq[i];
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge AXI_ACLK);
      #1;
    end
  endtask

  task automatic model_write(input int idx, input bit v, input logic [31:0] ip, mask, nh, oq);
    m_valid[idx] = v; m_ip[idx] = ip; m_mask[idx] = mask; m_nh[idx] = nh; m_oq[idx] = oq;
  endtask

  task automatic drive_wr(input int idx, input bit v, input logic [31:0] ip, mask, nh, oq);
    wr_index = 5'(idx); wr_entry_valid = v; wr_ip = ip; wr_mask = mask; wr_nh = nh; wr_oq = oq;
    wr_valid = 1'b1;
  endtask

  task automatic write_entry(input int idx, input bit v, input logic [31:0] ip, mask, nh, oq);
    int w = 0;
    while (!wr_ready && w < 64) begin step(1); w++; end
    chk("wr_ready_wait", {31'b0, wr_ready}, 32'd1);
    drive_wr(idx, v, ip, mask, nh, oq);
    step(1);
    wr_valid = 1'b0;
    model_write(idx, v, ip, mask, nh, oq);
    chk("valid_vec_after_wr", {31'b0, entry_valid_vec[idx]}, {31'b0, v});
  endtask

  task automatic start_req(input logic [31:0] ip);
    chk("req_ready_before_req", {31'b0, req_ready}, 32'd1);
    req_ip = ip;
    req_valid = 1'b1;
    model_lookup(ip);
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int cyc = 0;
    while (!rsp_valid && cyc < 100) begin step(1); cyc++; end
    chk({tag, "_latency"}, cyc, 32);
  endtask

  task automatic check_rsp(input string tag);
    chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_hit"},   {31'b0, rsp_hit},   {31'b0, e_hit});
    chk({tag, "_index"}, {27'b0, rsp_index}, {27'b0, e_idx});
    chk({tag, "_nh"},    rsp_nh, e_nh);
    chk({tag, "_oq"},    rsp_oq, e_oq);
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    m_lookups++;
    if (!e_hit) m_misses++;
    step(1);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_req_ready"},      {31'b0, req_ready}, 32'd1);
    chk({tag, "_lookup_count"},   lookup_count, m_lookups);
    chk({tag, "_miss_count"},     miss_count, m_misses);
  endtask

  // exp_idx >= 0 additionally pins the winning index to a hand-derived value.
  task automatic lookup(input logic [31:0] ip, input string tag, input int exp_idx);
    start_req(ip);
    wait_rsp(tag);
    check_rsp(tag);
    if (exp_idx >= 0) chk({tag, "_fixed_index"}, {27'b0, rsp_index}, exp_idx);
    ack_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int cyc;
    AXI_RESETN = 1'b0;
    req_valid = 1'b0; req_ip = '0; rsp_ready = 1'b0;
    wr_valid = 1'b0; wr_index = '0; wr_entry_valid = 1'b0;
    wr_ip = '0; wr_mask = '0; wr_nh = '0; wr_oq = '0;
    for (int i = 0; i < 32; i++) model_write(i, 1'b0, '0, '0, '0, '0);
    step(3);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wr_ready",  {31'b0, wr_ready},  32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_valid_vec", entry_valid_vec, 32'd0);
    chk("rst_lookups",   lookup_count, 32'd0);
    chk("rst_misses",    miss_count, 32'd0);
    chk("rst_rsp_hit",   {31'b0, rsp_hit}, 32'd0);
    chk("rst_rsp_nh",    rsp_nh, 32'd0);
    AXI_RESETN = 1'b1;
    step(2);

    // Empty table: miss, zeroed payload.
    lookup(32'h0A00_0001, "empty", 0);

    // Longest-prefix ordering.
    write_entry(3, 1'b1, 32'h0A00_0000, pmask(8),  32'h0101_0101, 32'd2);
    write_entry(7, 1'b1, 32'h0A01_0000, pmask(16), 32'h0202_0202, 32'd4);
    lookup(32'h0A01_0203, "lpm16", 7);
    chk("lpm16_nh_fixed", rsp_nh, 32'h0202_0202);
    lookup(32'h0A09_0001, "lpm8", 3);

    // Equal prefixes: the lower index wins.
    write_entry(5, 1'b1, 32'hC0A8_0000, pmask(24), 32'h0505_0505, 32'd5);
    write_entry(2, 1'b1, 32'hC0A8_0000, pmask(24), 32'h0606_0606, 32'd6);
    lookup(32'hC0A8_0009, "tie", 2);

    // Write arriving mid-scan is held off until DONE.
    start_req(32'h0A02_0005);
    step(5);
    drive_wr(1, 1'b1, 32'h0A02_0000, pmask(16), 32'h0303_0303, 32'd8);
    bad = 0;
    cyc = 5;
    while (!rsp_valid && cyc < 100) begin
      if (wr_ready) bad++;
      step(1);
      cyc++;
    end
    chk("midscan_latency", cyc, 32);
    chk("midscan_wr_ready_low", bad, 0);
    chk("midscan_wr_ready_done", {31'b0, wr_ready}, 32'd1);
    check_rsp("midscan_inflight");
    step(1);
    wr_valid = 1'b0;
    model_write(1, 1'b1, 32'h0A02_0000, pmask(16), 32'h0303_0303, 32'd8);
    chk("midscan_commit", {31'b0, entry_valid_vec[1]}, 32'd1);
    check_rsp("midscan_held");
    chk("midscan_fixed_index", {27'b0, rsp_index}, 32'd3);
    ack_rsp("midscan");
    lookup(32'h0A02_0005, "post_write", 1);

    // Backpressure with a write landing during DONE.
    start_req(32'h0A09_0001);
    wait_rsp("bp");
    for (int i = 0; i < 10; i++) begin
      check_rsp("bp_hold");
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_lookups", lookup_count, m_lookups);
      chk("bp_misses", miss_count, m_misses);
      if (i == 3) drive_wr(3, 1'b1, 32'h0A00_0000, pmask(8), 32'h0B0B_0B0B, 32'd9);
      if (i == 4) begin
        wr_valid = 1'b0;
        model_write(3, 1'b1, 32'h0A00_0000, pmask(8), 32'h0B0B_0B0B, 32'd9);
      end
      step(1);
    end
    ack_rsp("bp");
    lookup(32'h0A09_0001, "bp_after_wr", 3);

    // Invalidate entry 7: the /8 takes over.
    write_entry(7, 1'b0, 32'h0A01_0000, pmask(16), 32'h0202_0202, 32'd4);
    lookup(32'h0A01_0203, "invalidate", 3);

    // Write and request accepted on the same edge: scan sees the new entry.
    drive_wr(9, 1'b1, 32'h0A01_0203, pmask(32), 32'h0909_0909, 32'd11);
    model_write(9, 1'b1, 32'h0A01_0203, pmask(32), 32'h0909_0909, 32'd11);
    start_req(32'h0A01_0203);
    wr_valid = 1'b0;
    wait_rsp("same_edge");
    check_rsp("same_edge");
    chk("same_edge_fixed_index", {27'b0, rsp_index}, 32'd9);
    ack_rsp("same_edge");

    // Reset in the middle of a scan.
    start_req(32'h0A01_0203);
    step(10);
    #2;
    AXI_RESETN = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_valid_vec", entry_valid_vec, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_wr_ready",  {31'b0, wr_ready},  32'd1);
    chk("midrst_lookups",   lookup_count, 32'd0);
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_lookups = 0;
    m_misses = 0;
    step(2);
    AXI_RESETN = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) bad++;
      step(1);
    end
    chk("midrst_no_response", bad, 0);

    // Randomised table contents and lookups.
    for (int r = 0; r < 14; r++) begin
      int idx;
      int len;
      idx = $urandom_range(0, 31);
      len = $urandom_range(1, 32);
      write_entry(idx, ($urandom_range(0, 7) != 0), $urandom, pmask(len), $urandom, $urandom);
    end
    for (int r = 0; r < 16; r++) begin
      int k;
      logic [31:0] ip;
      k = $urandom_range(0, 31);
      if (m_valid[k] && ($urandom_range(0, 3) != 0))
        ip = (m_ip[k] & m_mask[k]) | ($urandom & ~m_mask[k]);
      else
        ip = $urandom;
      start_req(ip);
      wait_rsp("rand");
      step($urandom_range(0, 3));
      check_rsp("rand");
      ack_rsp("rand");
      if (r % 4 == 3) begin
        k = $urandom_range(0, 31);
        write_entry(k, 1'b1, $urandom, pmask($urandom_range(4, 28)), $urandom, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
